spi_slave_param: RTL and testbench
==================================

Name: spi_slave_param

Overview:
- Parametrised next-generation SPI slave for the SPI wrapper. It deserialises MOSI frames of 2 command bits plus DATA_W payload bits, MSB first, sampled directly on clk. Each completed frame is presented to the RAM-side logic as rx_data with a one-cycle rx_valid.
- On read-data commands it waits for tx_valid and serialises tx_data onto MISO.
- New relative to the previous generation:
  - generic payload width
  - back-to-back (burst) frames under a single SS_n assertion
  - a read-response timeout
  - a frame_err abort indication
  - a busy status output

Parameters:
- DATA_W, 8, payload width in bits. Frame width FRAME_W = DATA_W+2 is derived, not a parameter.
- BURST_EN, 0, 1 = after a completed frame/response with SS_n still low, the next frame starts immediately.
- TX_TIMEOUT, 16, max cycles spent in TX_WAIT before abort. 0 = wait forever.

Ports:
- clk  input  1  system clock, all sampling on rising edge
- rst_n  input  1  asynchronous active-low reset
- SS_n  input  1  slave select, active low
- MOSI  input  1  serial data in, MSB first
- MISO  output  1  serial data out (registered)
- rx_data  output  FRAME_W  last complete frame: [FRAME_W-1:FRAME_W-2] = command, rest = payload
- rx_valid  output  1  one-cycle pulse, rx_data updated
- tx_data  input  DATA_W  read response data
- tx_valid  input  1  tx_data valid, sampled only in TX_WAIT
- frame_err  output  1  one-cycle pulse on aborted frame or response
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; MISO=0, rx_data=0, rx_valid=0, frame_err=0, busy=0; shift registers and counters cleared.
- Commands (rx_data MSBs):
  - 00 = write address
  - 01 = write data
  - 10 = read address
  - 11 = read data
- States:
  - IDLE: an edge with SS_n=0 moves to RX with bit counter = FRAME_W. No MOSI bit is sampled at this edge.
  - RX: each edge with SS_n=0 shifts MOSI in and decrements the counter.
    - On the FRAME_W-th bit edge: rx_data <= {shift, MOSI} and rx_valid=1 for exactly one cycle, so rx_valid is visible in the cycle after edge E_FRAME_W, where E0 is the IDLE->RX edge.
    - Same edge: command 11 -> TX_WAIT (timeout counter=0); otherwise -> RX (counter reloaded) if BURST_EN=1, else DONE.
  - TX_WAIT:
    - Edge with tx_valid=1: latch tx_data, -> SEND with counter=DATA_W.
    - Otherwise the timeout counter increments. When TX_TIMEOUT != 0 and the counter reaches TX_TIMEOUT: frame_err pulse, -> DONE.
  - SEND:
    - Each edge: MISO <= latched MSB, shift left, decrement. The first bit appears on MISO after the edge that enters SEND+1.
    - After DATA_W bits driven: MISO <= 0 on the next edge; -> RX if BURST_EN=1, else DONE.
  - DONE: ignores MOSI, MISO=0; an edge with SS_n=1 -> IDLE.
- SS_n=1 at any edge in RX, TX_WAIT or SEND:
  - -> IDLE, MISO <= 0, frame_err pulses one cycle.
  - rx_valid is not asserted and rx_data keeps its previous value.
  - This includes SS_n rising at the edge that would have sampled the last bit: a bit counts only if SS_n=0 at its edge.
- In RX, rx_data only changes on frame completion. Partial frames never leak.
- rx_valid and frame_err are never high in the same cycle.
- tx_valid outside TX_WAIT is ignored. tx_data is captured once; later changes do not affect the bits in flight.
- Async reset mid-frame or mid-SEND: immediate return to reset values, no frame_err.

Test Plan:
- DATA_W=8, SS_n low, MOSI bits 0,0,1,0,1,0,0,1,0,1 -> rx_valid single pulse after the 10th bit edge, rx_data=10'h0A5, frame_err=0, then DONE until SS_n high -> IDLE, busy=0.
- Read-data frame 11_00000000, tx_valid=1 with tx_data=8'hC3 three cycles after rx_valid -> MISO sequence 1,1,0,0,0,0,1,1 on consecutive cycles, then MISO=0.
- SS_n raised after 5 of 10 bits -> frame_err one-cycle pulse, no rx_valid, rx_data unchanged, state IDLE next cycle.
- Read-data frame with tx_valid held 0, TX_TIMEOUT=16 -> frame_err pulse exactly 16 cycles after entering TX_WAIT, MISO stays 0.
- BURST_EN=1, SS_n held low, frames 00_0x11 then 01_0x22 back to back -> two rx_valid pulses 10 cycles apart, rx_data 10'h011 then 10'h122.
- rst_n asserted mid-SEND after 3 bits -> MISO, rx_valid, frame_err, busy all 0 immediately, without waiting for a clk edge; after release, a fresh frame is received correctly.

Source files
------------

// File: rtl/spi_slave_param_if.sv
// SPI slave bus bundle: serial pins plus the RAM-side frame/response handshake.
//   SS_n, MOSI        serial select and data in (driven by the master)
//   MISO              serial data out (driven by the slave)
//   rx_data/rx_valid  completed frame {cmd[1:0], payload} and its one-cycle strobe
//   tx_data/tx_valid  read response payload and its qualifier
//   frame_err         one-cycle pulse on an aborted frame or response
//   busy              slave is not idle
interface spi_slave_param_if #(
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned FRAME_W = DATA_W + 2;

  logic               SS_n;
  logic               MOSI;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;
  logic               frame_err;
  logic               busy;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, frame_err, busy
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, frame_err, busy
  );
endinterface

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave. Deserialises frames of 2 command bits + DATA_W payload bits
// (MSB first, sampled on clk), presents each frame as rx_data with a one-cycle rx_valid,
// and on a read-data command (11) waits for tx_valid and serialises tx_data onto MISO.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    spi_slave_param_if.slave (SS_n, MOSI, MISO, rx_*, tx_*, frame_err, busy)
// Parameters:
//   DATA_W      payload width
//   BURST_EN    1 = next frame starts straight away while SS_n stays low
//   TX_TIMEOUT  max cycles waiting for tx_valid, 0 = wait forever
module spi_slave_param #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          BURST_EN   = 1'b0,
  parameter int unsigned TX_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst_n,
  spi_slave_param_if.slave bus
);
  localparam int unsigned FRAME_W = DATA_W + 2;
  localparam int unsigned CntW    = $clog2(FRAME_W + 1);
  localparam int unsigned ToW     = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {StIdle, StRx, StTxWait, StSend, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [ToW-1:0]     to_cnt_q, to_cnt_d;
  logic [FRAME_W-2:0] shift_q, shift_d;
  logic [DATA_W-1:0]  tx_sh_q, tx_sh_d;
  logic               miso_q, miso_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               frame_err_q, frame_err_d;
  logic [FRAME_W-1:0] frame_full;

  // Frame as it would look if the current edge delivers the last bit.
  assign frame_full = {shift_q, bus.MOSI};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      to_cnt_q    <= '0;
      shift_q     <= '0;
      tx_sh_q     <= '0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      to_cnt_q    <= to_cnt_d;
      shift_q     <= shift_d;
      tx_sh_q     <= tx_sh_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    to_cnt_d    = to_cnt_q;
    shift_d     = shift_q;
    tx_sh_d     = tx_sh_q;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        miso_d = 1'b0;
        // No bit is sampled on the select edge itself.
        if (!bus.SS_n) begin
          state_d = StRx;
          cnt_d   = CntW'(FRAME_W);
          shift_d = '0;
        end
      end

      StRx: begin
        if (bus.SS_n) begin
          // A bit only counts with SS_n low, so a partial frame is dropped here.
          state_d     = StIdle;
          miso_d      = 1'b0;
          frame_err_d = 1'b1;
        end else begin
          shift_d = frame_full[FRAME_W-2:0];
          cnt_d   = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            rx_data_d  = frame_full;
            rx_valid_d = 1'b1;
            if (frame_full[FRAME_W-1:FRAME_W-2] == 2'b11) begin
              state_d  = StTxWait;
              to_cnt_d = '0;
            end else if (BURST_EN) begin
              cnt_d = CntW'(FRAME_W);
            end else begin
              state_d = StDone;
            end
          end
        end
      end

      StTxWait: begin
        miso_d = 1'b0;
        if (bus.SS_n) begin
          state_d     = StIdle;
          frame_err_d = 1'b1;
        end else if (bus.tx_valid) begin
          tx_sh_d = bus.tx_data;
          cnt_d   = CntW'(DATA_W);
          state_d = StSend;
        end else if (TX_TIMEOUT != 0) begin
          to_cnt_d = to_cnt_q + ToW'(1);
          if (32'(to_cnt_d) == TX_TIMEOUT) begin
            frame_err_d = 1'b1;
            state_d     = StDone;
          end
        end
      end

      StSend: begin
        if (bus.SS_n) begin
          state_d     = StIdle;
          miso_d      = 1'b0;
          frame_err_d = 1'b1;
        end else if (cnt_q != '0) begin
          miso_d  = tx_sh_q[DATA_W-1];
          tx_sh_d = tx_sh_q << 1;
          cnt_d   = cnt_q - CntW'(1);
        end else begin
          // Trailing edge after the last bit returns MISO low.
          miso_d = 1'b0;
          if (BURST_EN) begin
            state_d = StRx;
            cnt_d   = CntW'(FRAME_W);
          end else begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        miso_d = 1'b0;
        if (bus.SS_n) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign bus.MISO      = miso_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: dut0 is non-burst with TX_TIMEOUT=16,
// dut1 has BURST_EN=1. Inputs change on the falling edge, outputs are checked there too.
module tb_spi_slave_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  spi_slave_param_if #(.DATA_W(8)) if0 ();
  spi_slave_param_if #(.DATA_W(8)) if1 ();

  spi_slave_param #(.DATA_W(8), .BURST_EN(1'b0), .TX_TIMEOUT(16)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  spi_slave_param #(.DATA_W(8), .BURST_EN(1'b1), .TX_TIMEOUT(16)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shifts a frame into dut0, MSB first, one bit per edge.
  task automatic send0(input logic [9:0] f);
    for (int i = 9; i >= 0; i--) begin
      if0.MOSI = f[i];
      tick();
    end
  endtask

  initial begin
    logic [9:0] fr;
    logic [7:0] exp_bits;

    if0.SS_n = 1'b1; if0.MOSI = 1'b0; if0.tx_data = '0; if0.tx_valid = 1'b0;
    if1.SS_n = 1'b1; if1.MOSI = 1'b0; if1.tx_data = '0; if1.tx_valid = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_miso",      32'(if0.MISO),      32'd0);
    chk("rst_rx_data",   32'(if0.rx_data),   32'd0);
    chk("rst_rx_valid",  32'(if0.rx_valid),  32'd0);
    chk("rst_frame_err", 32'(if0.frame_err), 32'd0);
    chk("rst_busy",      32'(if0.busy),      32'd0);
    rst_n = 1'b1;
    tick();

    // Write frame 00_10100101 -> 0x0A5
    if0.SS_n = 1'b0;
    tick();
    chk("t1_busy_rx", 32'(if0.busy), 32'd1);
    fr = 10'b0010100101;
    for (int i = 9; i >= 0; i--) begin
      if0.MOSI = fr[i];
      tick();
      if (i > 0) chk("t1_no_early_valid", 32'(if0.rx_valid), 32'd0);
    end
    chk("t1_rx_valid",  32'(if0.rx_valid),  32'd1);
    chk("t1_rx_data",   32'(if0.rx_data),   32'h0A5);
    chk("t1_frame_err", 32'(if0.frame_err), 32'd0);
    tick();
    chk("t1_valid_pulse", 32'(if0.rx_valid), 32'd0);
    chk("t1_busy_done",   32'(if0.busy),     32'd1);
    if0.SS_n = 1'b1;
    tick();
    chk("t1_busy_idle", 32'(if0.busy), 32'd0);

    // Read-data frame, response 0xC3 three cycles later
    if0.SS_n = 1'b0;
    tick();
    send0(10'b1100000000);
    chk("t2_rx_valid", 32'(if0.rx_valid), 32'd1);
    chk("t2_rx_data",  32'(if0.rx_data),  32'h300);
    tick();
    tick();
    chk("t2_miso_wait", 32'(if0.MISO), 32'd0);
    if0.tx_valid = 1'b1;
    if0.tx_data  = 8'hC3;
    tick();
    if0.tx_valid = 1'b0;
    if0.tx_data  = 8'h00;
    chk("t2_miso_entry", 32'(if0.MISO), 32'd0);
    exp_bits = 8'b11000011;
    for (int i = 7; i >= 0; i--) begin
      tick();
      chk("t2_miso_bit", 32'(if0.MISO), 32'(exp_bits[i]));
    end
    tick();
    chk("t2_miso_tail", 32'(if0.MISO), 32'd0);
    if0.SS_n = 1'b1;
    tick();
    chk("t2_busy_idle", 32'(if0.busy), 32'd0);

    // Abort after 5 bits
    if0.SS_n = 1'b0;
    tick();
    fr = 10'b0111111111;
    for (int i = 9; i >= 5; i--) begin
      if0.MOSI = fr[i];
      tick();
    end
    if0.SS_n = 1'b1;
    tick();
    chk("t3_frame_err", 32'(if0.frame_err), 32'd1);
    chk("t3_no_valid",  32'(if0.rx_valid),  32'd0);
    chk("t3_rx_data",   32'(if0.rx_data),   32'h300);
    chk("t3_busy_idle", 32'(if0.busy),      32'd0);
    tick();
    chk("t3_err_pulse", 32'(if0.frame_err), 32'd0);

    // Read-data timeout with tx_valid held low
    if0.SS_n = 1'b0;
    tick();
    send0(10'b1100000000);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("t4_no_early_err", 32'(if0.frame_err), 32'd0);
    end
    tick();
    chk("t4_frame_err", 32'(if0.frame_err), 32'd1);
    chk("t4_miso",      32'(if0.MISO),      32'd0);
    tick();
    chk("t4_err_pulse", 32'(if0.frame_err), 32'd0);
    chk("t4_busy_done", 32'(if0.busy),      32'd1);
    if0.SS_n = 1'b1;
    tick();
    chk("t4_busy_idle", 32'(if0.busy), 32'd0);

    // Burst on dut1: 0x011 then 0x122 back to back
    if1.SS_n = 1'b0;
    tick();
    fr = 10'h011;
    for (int i = 9; i >= 0; i--) begin
      if1.MOSI = fr[i];
      tick();
    end
    chk("t5_valid_a", 32'(if1.rx_valid), 32'd1);
    chk("t5_data_a",  32'(if1.rx_data),  32'h011);
    fr = 10'h122;
    for (int i = 9; i >= 0; i--) begin
      if1.MOSI = fr[i];
      tick();
      if (i > 0) chk("t5_gap_no_valid", 32'(if1.rx_valid), 32'd0);
    end
    chk("t5_valid_b", 32'(if1.rx_valid), 32'd1);
    chk("t5_data_b",  32'(if1.rx_data),  32'h122);
    chk("t5_busy",    32'(if1.busy),     32'd1);
    if1.SS_n = 1'b1;
    tick();
    chk("t5_idle_err", 32'(if1.frame_err), 32'd1);
    chk("t5_data_kept", 32'(if1.rx_data), 32'h122);

    // Async reset mid-SEND after 3 bits of 0xFF
    if0.SS_n = 1'b0;
    tick();
    send0(10'b1100000000);
    if0.tx_valid = 1'b1;
    if0.tx_data  = 8'hFF;
    tick();
    if0.tx_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("t6_miso_before", 32'(if0.MISO), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_miso_rst",      32'(if0.MISO),      32'd0);
    chk("t6_rx_valid_rst",  32'(if0.rx_valid),  32'd0);
    chk("t6_frame_err_rst", 32'(if0.frame_err), 32'd0);
    chk("t6_busy_rst",      32'(if0.busy),      32'd0);
    chk("t6_rx_data_rst",   32'(if0.rx_data),   32'd0);
    if0.SS_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    if0.SS_n = 1'b0;
    tick();
    send0(10'b0101011010);
    chk("t6_fresh_valid", 32'(if0.rx_valid), 32'd1);
    chk("t6_fresh_data",  32'(if0.rx_data),  32'h15A);
    chk("t6_fresh_noerr", 32'(if0.frame_err), 32'd0);
    if0.SS_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
